// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//
// Central stall/flush sequencer for the five-stage RV32I pipeline. Every cycle
// it decides, from the hazard inputs and its own mul/div occupancy state, which
// of the PC and the four pipeline registers load, and which of them load a
// bubble instead of real contents. It also issues the one-cycle start pulse to
// the mul/div unit and counts the cycles in which the PC is held.
//
// Parameters
//   CNT_W         width of the stall-cycle counter (wraps modulo 2^CNT_W)
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous, active-high reset
//   id_rs1/rs2    source registers of the instruction in ID
//   id_uses_rs1/2 ID instruction actually reads that source
//   ex_rd         destination register of the instruction in EX
//   ex_mem_read   EX instruction is a load
//   ex_muldiv     EX holds a valid mul/div operation
//   muldiv_done   one-cycle pulse, mul/div result valid
//   ex_br_taken   EX redirects the PC (taken branch / jump)
//   imem_stall    I-cache cannot return an instruction this cycle
//   dmem_stall    D-cache busy with the MEM-stage access
//   pc_en .. mem_wb_en            register load enables
//   if_id_flush .. ex_mem_flush   load a bubble (only when the matching _en=1)
//   muldiv_go     one-cycle start pulse to the mul/div unit
//   stall_cycles  number of non-reset cycles with pc_en=0
//
// All outputs are combinational from the current state and inputs; only the
// FSM state and the stall counter are registered.
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_muldiv,
    input  logic             muldiv_done,
    input  logic             ex_br_taken,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             muldiv_go,
    output logic [CNT_W-1:0] stall_cycles
);

    // RUN     : normal issue, hazards resolved one cycle at a time
    // MD_BUSY : mul/div occupies EX, front end frozen, bubbles fed to MEM
    // MD_HOLD : result is ready but MEM is stalled; freeze everything so the
    //           result stays in EX until the D-cache lets go
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_BUSY = 2'd1,
        ST_MD_HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] stall_cycles_d;
    logic             load_use_s;

    // Load-use hazard: the load in EX writes a register the ID instruction
    // really reads. x0 is never a hazard since it is hard-wired to zero.
    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic       uses_rs1,
        input logic [4:0] rs2,
        input logic       uses_rs2
    );
        logic match_rs1;
        logic match_rs2;
        match_rs1 = uses_rs1 && (rd == rs1);
        match_rs2 = uses_rs2 && (rd == rs2);
        return mem_read && (rd != 5'd0) && (match_rs1 || match_rs2);
    endfunction

    assign load_use_s = load_use_hit(ex_mem_read, ex_rd, id_rs1, id_uses_rs1,
                                     id_rs2, id_uses_rs2);

    // Next-state and enable/flush decode from state plus hazard inputs.
    always_comb begin
        state_d      = state_q;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        muldiv_go    = 1'b0;

        if (rst) begin
            // Hold every register and request bubbles so nothing stale
            // survives once the enables come back.
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_d      = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (dmem_stall) begin
                        // MEM cannot complete: the whole pipe waits.
                        state_d = ST_RUN;
                    end else if (ex_muldiv) begin
                        // Start the unit; the op stays parked in EX while the
                        // instruction ahead of it drains to WB.
                        muldiv_go    = 1'b1;
                        ex_mem_en    = 1'b1;
                        ex_mem_flush = 1'b1;
                        mem_wb_en    = 1'b1;
                        state_d      = ST_MD_BUSY;
                    end else if (ex_br_taken) begin
                        // Redirect wins over load-use and I-cache stalls: the
                        // instructions in IF and ID are wrong-path anyway.
                        pc_en       = 1'b1;
                        if_id_en    = 1'b1;
                        id_ex_en    = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use_s) begin
                        // One bubble into EX; forwarding from MEM covers the
                        // dependent instruction on the following cycle.
                        id_ex_en    = 1'b1;
                        id_ex_flush = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                    end else if (imem_stall) begin
                        // No instruction fetched: keep PC, bubble into ID.
                        if_id_en    = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_en    = 1'b1;
                        ex_mem_en   = 1'b1;
                        mem_wb_en   = 1'b1;
                    end else begin
                        pc_en     = 1'b1;
                        if_id_en  = 1'b1;
                        id_ex_en  = 1'b1;
                        ex_mem_en = 1'b1;
                        mem_wb_en = 1'b1;
                    end
                end

                ST_MD_BUSY: begin
                    if (dmem_stall) begin
                        // Freeze; a result arriving now must not be dropped.
                        if (muldiv_done) begin
                            state_d = ST_MD_HOLD;
                        end else begin
                            state_d = ST_MD_BUSY;
                        end
                    end else if (muldiv_done) begin
                        // Result moves on and the next instruction enters EX.
                        pc_en     = 1'b1;
                        if_id_en  = 1'b1;
                        id_ex_en  = 1'b1;
                        ex_mem_en = 1'b1;
                        mem_wb_en = 1'b1;
                        state_d   = ST_RUN;
                    end else begin
                        ex_mem_en    = 1'b1;
                        ex_mem_flush = 1'b1;
                        mem_wb_en    = 1'b1;
                        state_d      = ST_MD_BUSY;
                    end
                end

                ST_MD_HOLD: begin
                    if (dmem_stall) begin
                        state_d = ST_MD_HOLD;
                    end else begin
                        pc_en     = 1'b1;
                        if_id_en  = 1'b1;
                        id_ex_en  = 1'b1;
                        ex_mem_en = 1'b1;
                        mem_wb_en = 1'b1;
                        state_d   = ST_RUN;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to RUN with the pipe held.
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Stall counter next value: cleared by reset, +1 whenever the PC is held.
    always_comb begin
        if (rst) begin
            stall_cycles_d = CNT_ZERO;
        end else if (!pc_en) begin
            stall_cycles_d = stall_cycles_q + CNT_ONE;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // FSM state and stall counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            stall_cycles_q <= CNT_ZERO;
        end else begin
            state_q        <= state_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_muldiv;
    logic             muldiv_done;
    logic             ex_br_taken;
    logic             imem_stall;
    logic             dmem_stall;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             mem_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic             muldiv_go;
    logic [CNT_W-1:0] stall_cycles;

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_muldiv    (ex_muldiv),
        .muldiv_done  (muldiv_done),
        .ex_br_taken  (ex_br_taken),
        .imem_stall   (imem_stall),
        .dmem_stall   (dmem_stall),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_en     (id_ex_en),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_en    (mem_wb_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .muldiv_go    (muldiv_go),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs packed as {pc,if_id,id_ex,ex_mem,mem_wb, if_id_fl,id_ex_fl,ex_mem_fl, go}
    localparam logic [8:0] E_RST  = 9'b00000_111_0;
    localparam logic [8:0] E_ALL  = 9'b11111_000_0;
    localparam logic [8:0] E_FRZ  = 9'b00000_000_0;
    localparam logic [8:0] E_GO   = 9'b00011_001_1;
    localparam logic [8:0] E_BUSY = 9'b00011_001_0;
    localparam logic [8:0] E_BR   = 9'b11111_110_0;
    localparam logic [8:0] E_LU   = 9'b00111_010_0;
    localparam logic [8:0] E_IM   = 9'b01111_100_0;

    typedef struct {
        logic       rst;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic       md;
        logic       done;
        logic       br;
        logic       im;
        logic       dm;
        logic [8:0] exp;
    } vec_t;

    vec_t             tbl[$];
    int               n_tests;
    int               n_fail;
    logic [CNT_W-1:0] exp_cnt;

    function automatic vec_t v(input logic r, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic u1, input logic u2,
                               input logic mr, input logic md, input logic done,
                               input logic br, input logic im, input logic dm,
                               input logic [8:0] exp);
        vec_t t;
        t.rst = r;   t.rd = rd;   t.rs1 = rs1;  t.rs2 = rs2;
        t.u1 = u1;   t.u2 = u2;   t.mr = mr;    t.md = md;
        t.done = done; t.br = br; t.im = im;    t.dm = dm;
        t.exp = exp;
        return t;
    endfunction

    // Apply one vector at the falling edge, compare mid-cycle, then advance
    // the counter model for the rising edge that follows.
    task automatic step(input vec_t t, input int idx);
        logic [8:0] got;
        @(negedge clk);
        rst = t.rst;         ex_rd = t.rd;       id_rs1 = t.rs1;      id_rs2 = t.rs2;
        id_uses_rs1 = t.u1;  id_uses_rs2 = t.u2; ex_mem_read = t.mr;  ex_muldiv = t.md;
        muldiv_done = t.done; ex_br_taken = t.br; imem_stall = t.im;  dmem_stall = t.dm;
        #2;
        got = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, ex_mem_flush, muldiv_go};
        n_tests++;
        if (got !== t.exp) begin
            n_fail++;
            $display("FAIL vec[%0d] outputs: got %b, expected %b", idx, got, t.exp);
        end
        n_tests++;
        if (stall_cycles !== exp_cnt) begin
            n_fail++;
            $display("FAIL vec[%0d] stall_cycles: got %0d, expected %0d", idx, stall_cycles, exp_cnt);
        end
        if (t.rst) exp_cnt = '0;
        else if (!t.exp[8]) exp_cnt = exp_cnt + 1'b1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_cnt = '0;
        rst = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0; ex_muldiv = 1'b0;
        muldiv_done = 1'b0; ex_br_taken = 1'b0; imem_stall = 1'b0; dmem_stall = 1'b0;

        //                 rst rd    rs1   rs2   u1 u2 mr md dn br im dm  exp
        tbl.push_back(v(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST));
        tbl.push_back(v(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, E_RST));
        tbl.push_back(v(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, E_ALL));
        // load-use on rs1, then forwarding cycle with no stall
        tbl.push_back(v(0, 5'd5, 5'd5, 5'd0, 1, 0, 1, 0, 0, 0, 0, 0, E_LU));
        tbl.push_back(v(0, 5'd9, 5'd5, 5'd0, 1, 0, 0, 0, 0, 0, 0, 0, E_ALL));
        // ex_rd = x0 is never a hazard
        tbl.push_back(v(0, 5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 0, 0, 0, 0, E_ALL));
        // match on rs2 only, then same match but rs2 not used
        tbl.push_back(v(0, 5'd7, 5'd3, 5'd7, 1, 1, 1, 0, 0, 0, 0, 0, E_LU));
        tbl.push_back(v(0, 5'd7, 5'd3, 5'd7, 1, 0, 1, 0, 0, 0, 0, 0, E_ALL));
        // register match but EX is not a load
        tbl.push_back(v(0, 5'd5, 5'd5, 5'd5, 1, 1, 0, 0, 0, 0, 0, 0, E_ALL));
        // redirect beats load-use + imem; dmem beats everything
        tbl.push_back(v(0, 5'd5, 5'd5, 5'd0, 1, 0, 1, 0, 0, 1, 1, 0, E_BR));
        tbl.push_back(v(0, 5'd5, 5'd5, 5'd0, 1, 0, 1, 0, 0, 1, 1, 1, E_FRZ));
        // stray muldiv_done in RUN is ignored
        tbl.push_back(v(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 0, E_ALL));
        // I-cache miss for five cycles
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 1, 0, E_IM));
        tbl.push_back(v(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 1, E_FRZ));
        // load-use beats imem
        tbl.push_back(v(0, 5'd4, 5'd0, 5'd4, 0, 1, 1, 0, 0, 0, 1, 0, E_LU));
        // mul/div: go, three busy cycles, done 4 cycles after go
        tbl.push_back(v(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, 0, E_GO));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, 0, E_BUSY));
        tbl.push_back(v(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0, 0, 0, E_ALL));
        tbl.push_back(v(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, E_ALL));
        // mul/div with done during D-cache stall -> MD_HOLD (counter wraps here)
        tbl.push_back(v(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, 0, E_GO));
        tbl.push_back(v(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, 0, E_BUSY));
        tbl.push_back(v(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, 1, E_FRZ));
        tbl.push_back(v(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0, 0, 1, E_FRZ));
        tbl.push_back(v(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, 1, E_FRZ));
        tbl.push_back(v(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, 1, E_FRZ));
        tbl.push_back(v(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, 0, E_ALL));
        tbl.push_back(v(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 0, E_ALL));
        // reset in MD_BUSY: back to RUN (idle gives E_ALL, not E_BUSY)
        tbl.push_back(v(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, 0, E_GO));
        tbl.push_back(v(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, 0, E_BUSY));
        tbl.push_back(v(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, 0, E_RST));
        tbl.push_back(v(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, E_ALL));
        // reset in MD_HOLD: back to RUN (imem stall gives E_IM, not E_ALL)
        tbl.push_back(v(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, 0, E_GO));
        tbl.push_back(v(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0, 0, 1, E_FRZ));
        tbl.push_back(v(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, 1, E_RST));
        tbl.push_back(v(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 1, 0, E_IM));

        foreach (tbl[i]) step(tbl[i], i);

        // Hand sequence: drive the counter to its maximum, then stall once to wrap.
        while (exp_cnt != {CNT_W{1'b1}})
            step(v(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 1, 0, E_IM), 1000);
        step(v(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 1, 0, E_IM), 1001);
        step(v(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0, E_ALL), 1002);
        n_tests++;
        if (stall_cycles !== {CNT_W{1'b0}}) begin
            n_fail++;
            $display("FAIL wrap: stall_cycles got %0d, expected 0", stall_cycles);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage RV32I pipeline. It sits beside the EX-stage forwarding logic. Each cycle it drives the write-enables and bubble-inserts of the PC and the four pipeline registers. It resolves load-use hazards, multi-cycle mul/div occupancy of EX, I-/D-cache wait states and EX-stage branch redirects. It also owns the mul/div start handshake and a stall-cycle performance counter.

## Interface
Parameters:
- CNT_W, 32, width of stall-cycle counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- id_rs1, id_rs2  in  5 each  source registers of instruction in ID
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction actually reads that source
- ex_rd  in  5  destination of instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_muldiv  in  1  EX holds a valid mul/div op
- muldiv_done  in  1  one-cycle pulse, result valid
- ex_br_taken  in  1  EX redirects PC (taken branch/jump)
- imem_stall  in  1  I-cache cannot return an instruction this cycle
- dmem_stall  in  1  D-cache busy with MEM-stage access
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables
- if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  load a bubble (takes effect only when matching _en=1)
- muldiv_go  out  1  one-cycle start pulse to mul/div unit
- stall_cycles  out  CNT_W  count of cycles with pc_en=0

## Operation
- FSM states: RUN, MD_BUSY, MD_HOLD. Reset state RUN.
- During rst: all *_en=0, all *_flush=1, muldiv_go=0, stall_cycles cleared to 0 on the edge.
- Decision order in RUN, highest priority first:
  1. dmem_stall=1: all enables 0, no flush, no muldiv_go, stay RUN.
  2. ex_muldiv=1: muldiv_go=1; pc/if_id/id_ex enables 0; ex_mem_en=1 with ex_mem_flush=1; mem_wb_en=1; go to MD_BUSY.
  3. ex_br_taken=1: all enables 1; if_id_flush=1 and id_ex_flush=1. Redirect overrides imem_stall and load-use.
  4. Load-use: ex_mem_read=1, ex_rd!=0, and (ex_rd==id_rs1 with id_uses_rs1, or ex_rd==id_rs2 with id_uses_rs2). pc_en=0, if_id_en=0, id_ex_en=1 with id_ex_flush=1, downstream enabled. This is exactly one bubble; forwarding covers the next cycle.
  5. imem_stall=1: pc_en=0, if_id_en=1 with if_id_flush=1, downstream enabled.
  6. Otherwise: all enables 1, no flush.
- MD_BUSY:
  - pc/if_id/id_ex frozen; ex_mem gets a bubble each cycle; mem_wb advances.
  - When dmem_stall=1, everything is frozen instead.
  - muldiv_done with dmem_stall=0: all enables 1, no flush; go to RUN.
  - muldiv_done with dmem_stall=1: all enables 0; go to MD_HOLD, so the result is not lost.
- MD_HOLD:
  - All enables 0 while dmem_stall=1.
  - On dmem_stall=0: all enables 1; go to RUN.
- muldiv_done is ignored in RUN. muldiv_go is never asserted outside the RUN→MD_BUSY transition.
- stall_cycles: +1 on every non-reset cycle with pc_en=0. Wraps modulo 2^CNT_W.

## Timing
- All outputs are combinational from state plus inputs. State and counter update on the rising clk edge.
- Load-use costs exactly 1 cycle. Branch redirect costs 2 bubbles and 0 stall cycles.
- Mul/div occupancy: from the muldiv_go cycle through the cycle before muldiv_done, plus any MD_HOLD cycles.
- In the done cycle, a new instruction is latched into EX. No re-issue of muldiv_go occurs for the finished op.
- Reset asserted mid-MD_BUSY/MD_HOLD returns the FSM to RUN next edge. No muldiv_go during reset.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 → one cycle of pc_en=0, if_id_en=0, id_ex_flush=1; stall_cycles 0→1. With ex_rd=0 → no stall.
- Mul/div: ex_muldiv=1 in RUN, muldiv_done 4 cycles later → muldiv_go for exactly 1 cycle; pc_en=0 for 4 cycles with ex_mem_flush=1; done cycle has all enables 1; FSM back in RUN; stall_cycles=4.
- Done during D-cache stall: in MD_BUSY, muldiv_done=1 with dmem_stall=1 for 3 cycles → MD_HOLD; all enables 0 until dmem_stall drops; then all enables 1 and RUN.
- Priority: ex_br_taken=1 together with a load-use match and imem_stall=1 → pc_en=1, if_id_flush=1, id_ex_flush=1, no stall. Adding dmem_stall=1 → all enables 0.
- I-cache miss: imem_stall=1 for 5 cycles → pc_en=0 and if_id_flush=1 each cycle, id_ex_en=1; stall_cycles +5.
- Reset: rst=1 while in MD_BUSY → all enables 0, flushes 1; after release, state RUN, stall_cycles=0, no muldiv_go. Preload counter to 2^CNT_W−1 and stall once → wraps to 0.
